// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - shared register-file widths, writeback entry type and source enum
package processor_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 64;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       value;
  } wb_entry_t;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - circular result FIFO with an entry/valid view for hazard tracking
module wb_fifo
  import processor_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = wb_entry_t
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  entry_t                  push_entry,
  input  logic                    pop,
  output entry_t                  head,
  output logic                    full,
  output logic                    empty,
  output entry_t [DEPTH-1:0]      entries,
  output logic   [DEPTH-1:0]      entry_valid
);

  localparam int PW = $clog2(DEPTH);

  // Extra pointer bit distinguishes full from empty when the index bits match.
  logic   [PW:0]      wr_ptr;
  logic   [PW:0]      rd_ptr;
  logic   [PW:0]      count;
  logic   [PW-1:0]    offset [DEPTH];
  entry_t [DEPTH-1:0] mem;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[PW-1:0]];
  assign entries = mem;

  // Advance pointers on accepted push/pop; both may happen in one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; entry_valid masks stale slots.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[PW-1:0]] <= push_entry;
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      offset[i]      = PW'(i) - rd_ptr[PW-1:0];
      entry_valid[i] = ({1'b0, offset[i]} < count);
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - ALU/load result queues arbitrated round-robin onto the register-file write port
module writeback_stage
  import processor_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_value,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_value,
  output logic                  mem_ready,
  output logic                  write_enable,
  output logic [REG_ADDR_W-1:0] write_register,
  output logic [XLEN-1:0]       write_value,
  input  logic                  write_ready,
  output logic [31:0]           pending_mask
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       value;
  } entry_t;

  entry_t                  alu_in, mem_in, alu_head, mem_head, slot;
  entry_t [FIFO_DEPTH-1:0] alu_entries, mem_entries;
  logic   [FIFO_DEPTH-1:0] alu_live, mem_live;
  logic                    alu_full, alu_empty, mem_full, mem_empty;
  logic                    slot_valid, slot_load;
  logic                    grant_alu, grant_mem;
  wb_src_e                 last_grant;

  assign alu_ready = !alu_full;
  assign mem_ready = !mem_full;
  assign alu_in    = '{rd: alu_rd, value: alu_value};
  assign mem_in    = '{rd: mem_rd, value: mem_value};

  // x0 writes finish the handshake but are never stored.
  wb_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(entry_t)) u_alu_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (alu_valid && alu_ready && (alu_rd != '0)),
    .push_entry (alu_in),
    .pop        (slot_load && grant_alu),
    .head       (alu_head),
    .full       (alu_full),
    .empty      (alu_empty),
    .entries    (alu_entries),
    .entry_valid(alu_live)
  );

  wb_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(entry_t)) u_mem_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (mem_valid && mem_ready && (mem_rd != '0)),
    .push_entry (mem_in),
    .pop        (slot_load && grant_mem),
    .head       (mem_head),
    .full       (mem_full),
    .empty      (mem_empty),
    .entries    (mem_entries),
    .entry_valid(mem_live)
  );

  // Slot refills when empty or when its current write is being accepted.
  assign slot_load = !slot_valid || write_ready;
  assign grant_alu = !alu_empty && (mem_empty || last_grant == WB_SRC_MEM);
  assign grant_mem = !mem_empty && !grant_alu;

  assign write_enable   = slot_valid;
  assign write_register = slot.rd;
  assign write_value    = slot.value;

  // Output slot and round-robin pointer; the pointer only moves on contention.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_valid <= 1'b0;
      slot       <= '0;
      last_grant <= WB_SRC_MEM;
    end else if (slot_load) begin
      if (grant_alu) begin
        slot       <= alu_head;
        slot_valid <= 1'b1;
      end else if (grant_mem) begin
        slot       <= mem_head;
        slot_valid <= 1'b1;
      end else begin
        slot_valid <= 1'b0;
      end
      if (!alu_empty && !mem_empty) last_grant <= grant_alu ? WB_SRC_ALU : WB_SRC_MEM;
    end
  end

  // Every queued or in-flight destination register, x0 excluded.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (alu_live[i]) pending_mask[alu_entries[i].rd] = 1'b1;
      if (mem_live[i]) pending_mask[mem_entries[i].rd] = 1'b1;
    end
    if (slot_valid) pending_mask[slot.rd] = 1'b1;
    pending_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - randomized and directed checks of writeback_stage against a queue model
module tb_writeback_stage;

  localparam int XLEN  = 64;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            alu_valid = 1'b0, mem_valid = 1'b0, write_ready = 1'b1;
  logic [4:0]      alu_rd = '0, mem_rd = '0;
  logic [XLEN-1:0] alu_value = '0, mem_value = '0;
  logic            alu_ready, mem_ready, write_enable;
  logic [4:0]      write_register;
  logic [XLEN-1:0] write_value;
  logic [31:0]     pending_mask;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] value;
  } ent_t;

  ent_t aq[$];
  ent_t mq[$];
  bit   s_v = 0;
  ent_t s_e;
  bit   lg_mem = 1;

  writeback_stage #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_value     (alu_value),
    .alu_ready     (alu_ready),
    .mem_valid     (mem_valid),
    .mem_rd        (mem_rd),
    .mem_value     (mem_value),
    .mem_ready     (mem_ready),
    .write_enable  (write_enable),
    .write_register(write_register),
    .write_value   (write_value),
    .write_ready   (write_ready),
    .pending_mask  (pending_mask)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_pending();
    logic [31:0] m = '0;
    foreach (aq[i]) m[aq[i].rd] = 1'b1;
    foreach (mq[i]) m[mq[i].rd] = 1'b1;
    if (s_v) m[s_e.rd] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  // One clock: apply the edge to the model with the inputs currently driven, then settle at negedge.
  task automatic tick();
    bit a_acc, m_acc;
    @(posedge clk);
    a_acc = alu_valid && (aq.size() < DEPTH);
    m_acc = mem_valid && (mq.size() < DEPTH);
    if (!s_v || write_ready) begin
      if (aq.size() > 0 && mq.size() > 0) begin
        if (lg_mem) begin s_e = aq.pop_front(); lg_mem = 0; end
        else begin s_e = mq.pop_front(); lg_mem = 1; end
        s_v = 1;
      end else if (aq.size() > 0) begin
        s_e = aq.pop_front(); s_v = 1;
      end else if (mq.size() > 0) begin
        s_e = mq.pop_front(); s_v = 1;
      end else begin
        s_v = 0;
      end
    end
    if (a_acc && alu_rd != 0) aq.push_back('{alu_rd, alu_value});
    if (m_acc && mem_rd != 0) mq.push_back('{mem_rd, mem_value});
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (write_enable !== 1'b0 || write_register !== 5'd0 || write_value !== '0 || pending_mask !== '0) begin
      errors++;
      $display("FAIL reset_outputs we=%0b reg=%0d val=%h mask=%h exp all zero", write_enable, write_register, write_value, pending_mask);
    end
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (write_enable !== 1'b0 || alu_ready !== 1'b1 || mem_ready !== 1'b1 || pending_mask !== '0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d we=%0b ar=%0b mr=%0b mask=%h exp 0/1/1/0", k, write_enable, alu_ready, mem_ready, pending_mask);
      end
    end
  endtask

  task automatic test_single();
    write_ready = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_value = 64'hDEAD_BEEF;
    tick();
    alu_valid = 1'b0;
    checks++;
    if (write_enable !== 1'b0 || pending_mask !== 32'h20) begin
      errors++;
      $display("FAIL single_queued we=%0b mask=%h exp we=0 mask=00000020", write_enable, pending_mask);
    end
    tick();
    checks++;
    if (write_enable !== 1'b1 || write_register !== 5'd5 || write_value !== 64'hDEAD_BEEF || pending_mask !== 32'h20) begin
      errors++;
      $display("FAIL single_write we=%0b reg=%0d val=%h mask=%h exp 1/5/deadbeef/20", write_enable, write_register, write_value, pending_mask);
    end
    tick();
    checks++;
    if (write_enable !== 1'b0 || pending_mask !== '0) begin
      errors++;
      $display("FAIL single_done we=%0b mask=%h exp 0/0", write_enable, pending_mask);
    end
  endtask

  task automatic test_arbitration();
    write_ready = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_value = 64'h33;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_value = 64'h44;
    tick();
    alu_valid = 1'b0; mem_valid = 1'b0;
    tick();
    checks++;
    if (write_enable !== 1'b1 || write_register !== 5'd3 || write_value !== 64'h33) begin
      errors++;
      $display("FAIL arb_first we=%0b reg=%0d exp 1/3", write_enable, write_register);
    end
    tick();
    checks++;
    if (write_enable !== 1'b1 || write_register !== 5'd4 || write_value !== 64'h44) begin
      errors++;
      $display("FAIL arb_second we=%0b reg=%0d exp 1/4", write_enable, write_register);
    end
    for (int k = 0; k < 10; k++) begin
      alu_valid = 1'b1; alu_rd = 5'(8 + k); alu_value = 64'(1000 + k);
      mem_valid = 1'b1; mem_rd = 5'(20 + k); mem_value = 64'(2000 + k);
      tick();
      checks++;
      if (write_enable !== s_v || (s_v && (write_register !== s_e.rd || write_value !== s_e.value))) begin
        errors++;
        $display("FAIL arb_stream cyc=%0d we=%0b reg=%0d exp %0b/%0d", k, write_enable, write_register, s_v, s_e.rd);
      end
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    repeat (12) tick();
    checks++;
    if (write_enable !== 1'b0 || pending_mask !== '0) begin
      errors++;
      $display("FAIL arb_drain we=%0b mask=%h exp 0/0", write_enable, pending_mask);
    end
  endtask

  task automatic test_backpressure();
    int accepted = 0;
    write_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (!alu_ready) break;
      alu_valid = 1'b1; alu_rd = 5'(10 + accepted); alu_value = 64'(100 + accepted);
      tick();
      accepted++;
    end
    alu_valid = 1'b0;
    checks++;
    if (accepted != DEPTH + 1 || alu_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_fill accepted=%0d ready=%0b exp %0d/0", accepted, alu_ready, DEPTH + 1);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (write_enable !== 1'b1 || write_register !== 5'd10 || write_value !== 64'd100) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d we=%0b reg=%0d val=%0d exp 1/10/100", k, write_enable, write_register, write_value);
      end
    end
    write_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (write_enable !== 1'b1 || write_register !== 5'(10 + k) || write_value !== 64'(100 + k)) begin
        errors++;
        $display("FAIL bp_drain idx=%0d we=%0b reg=%0d val=%0d exp 1/%0d/%0d", k, write_enable, write_register, write_value, 10 + k, 100 + k);
      end
      tick();
    end
    checks++;
    if (write_enable !== 1'b0 || alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_empty we=%0b ready=%0b exp 0/1", write_enable, alu_ready);
    end
  endtask

  task automatic test_x0();
    write_ready = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_value = 64'd7;
    checks++;
    if (alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL x0_ready got %0b exp 1", alu_ready);
    end
    tick();
    alu_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (write_enable !== 1'b0 || pending_mask !== '0) begin
        errors++;
        $display("FAIL x0_nowrite cyc=%0d we=%0b mask=%h exp 0/0", k, write_enable, pending_mask);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      alu_valid   = 1'($urandom_range(0, 1));
      alu_rd      = 5'($urandom_range(0, 31));
      alu_value   = {32'($urandom), 32'($urandom)};
      mem_valid   = 1'($urandom_range(0, 1));
      mem_rd      = 5'($urandom_range(0, 31));
      mem_value   = {32'($urandom), 32'($urandom)};
      write_ready = ($urandom_range(0, 3) != 0);
      tick();
      checks++;
      if (write_enable !== s_v || (s_v && (write_register !== s_e.rd || write_value !== s_e.value))) begin
        errors++;
        $display("FAIL rand_write cyc=%0d we=%0b reg=%0d val=%h exp %0b/%0d/%h", k, write_enable, write_register, write_value, s_v, s_e.rd, s_e.value);
      end
      checks++;
      if (alu_ready !== (aq.size() < DEPTH) || mem_ready !== (mq.size() < DEPTH)) begin
        errors++;
        $display("FAIL rand_ready cyc=%0d ar=%0b mr=%0b exp %0b/%0b", k, alu_ready, mem_ready, aq.size() < DEPTH, mq.size() < DEPTH);
      end
      checks++;
      if (pending_mask !== model_pending()) begin
        errors++;
        $display("FAIL rand_mask cyc=%0d got %h exp %h", k, pending_mask, model_pending());
      end
    end
    alu_valid = 1'b0; mem_valid = 1'b0; write_ready = 1'b1;
    repeat (12) tick();
  endtask

  task automatic test_async_reset();
    write_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      alu_valid = 1'b1; alu_rd = 5'($urandom_range(1, 31)); alu_value = 64'(k);
      mem_valid = 1'b1; mem_rd = 5'($urandom_range(1, 31)); mem_value = 64'(k + 50);
      tick();
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    checks++;
    if (pending_mask !== model_pending() || alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL ar_filled mask=%h ar=%0b mr=%0b exp %h/0/0", pending_mask, alu_ready, mem_ready, model_pending());
    end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    aq.delete(); mq.delete(); s_v = 0; lg_mem = 1;
    checks++;
    if (write_enable !== 1'b0 || write_register !== 5'd0 || write_value !== '0 || pending_mask !== '0 ||
        alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
      errors++;
      $display("FAIL ar_immediate we=%0b reg=%0d val=%h mask=%h ar=%0b mr=%0b exp 0/0/0/0/1/1",
               write_enable, write_register, write_value, pending_mask, alu_ready, mem_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    write_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (write_enable !== 1'b0 || pending_mask !== '0) begin
        errors++;
        $display("FAIL ar_no_stale cyc=%0d we=%0b mask=%h exp 0/0", k, write_enable, pending_mask);
      end
    end
  endtask

  initial begin
    s_e = '{5'd0, '0};
    test_reset();
    test_single();
    test_arbitration();
    test_backpressure();
    test_x0();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
